// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver feeding an FWFT byte FIFO; PS2_PREFIX_DECODE_EN folds E0/F0 prefixes into ext/brk flags.
// Latency: byte visible on rd_valid/rd_data one cycle after the stop-bit edge pulse.
// Backpressure: none toward the PS/2 line; full FIFO drops the frame and pulses overflow.
module ps2_rx_fifo #(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             PS2_CLK,
    input  logic             PS2_DAT,
    input  logic             rd_en,
    output logic [9:0]       rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    output logic             frame_error
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic                  dat_s1_q, dat_s2_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  lvl_q, lvl_d, fall;
    state_t                state_q, state_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic [7:0]            code_q, code_d;
    logic                  par_q, par_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;
    logic                  ferr_q, ferr_d, ovf_q, ovf_d;
    logic                  good, push, pop, full, wr_en;
    logic [9:0]            push_dat;
    logic [9:0]            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
`ifdef PS2_PREFIX_DECODE_EN
    logic                  ext_q, ext_d, brk_q, brk_d;
`endif

    always_comb begin
        filt_d = {filt_q[FILTER_LEN-2:0], PS2_CLK};
        lvl_d  = lvl_q;
        if (&filt_q)       lvl_d = 1'b1;
        else if (~|filt_q) lvl_d = 1'b0;
        fall = lvl_q & ~lvl_d;
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        code_d   = code_q;
        par_d    = par_q;
        wdog_d   = '0;
        good     = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: if (fall && !dat_s2_q) begin
                state_d  = DATA;
                bitcnt_d = 3'd0;
            end
            DATA: if (fall) begin
                code_d   = {dat_s2_q, code_q[7:1]};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (fall) begin
                par_d   = dat_s2_q;
                state_d = STOP;
            end
            STOP: if (fall) begin
                state_d = IDLE;
                if (dat_s2_q && (^{code_q, par_q})) good   = 1'b1;
                else                                ferr_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Watchdog only runs between edges of an open frame.
        if (state_q != IDLE && !fall) begin
            if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
                ferr_d  = 1'b1;
            end else begin
                wdog_d = wdog_q + WD_W'(1);
            end
        end
    end

`ifdef PS2_PREFIX_DECODE_EN
    always_comb begin
        push     = 1'b0;
        push_dat = {ext_q, brk_q, code_q};
        ext_d    = ext_q;
        brk_d    = brk_q;
        if (good) begin
            if (code_q == 8'hE0)      ext_d = 1'b1;
            else if (code_q == 8'hF0) brk_d = 1'b1;
            else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
        if (ferr_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end
`else
    always_comb begin
        push     = good;
        push_dat = {2'b00, code_q};
    end
`endif

    always_comb begin
        full  = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop   = rd_en && (cnt_q != '0);
        wr_en = push && (!full || pop);
        ovf_d = push && full && !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!wr_en && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= '1;
            lvl_q    <= 1'b1;
            state_q  <= IDLE;
            bitcnt_q <= '0;
            code_q   <= '0;
            par_q    <= 1'b0;
            wdog_q   <= '0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
`ifdef PS2_PREFIX_DECODE_EN
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
`endif
        end else begin
            dat_s1_q <= PS2_DAT;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            lvl_q    <= lvl_d;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            code_q   <= code_d;
            par_q    <= par_d;
            wdog_q   <= wdog_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
`ifdef PS2_PREFIX_DECODE_EN
            ext_q    <= ext_d;
            brk_q    <= brk_d;
`endif
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_dat;
    end

    assign rd_valid    = (cnt_q != '0);
    assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : 10'd0;
    assign fifo_count  = cnt_q;
    assign overflow    = ovf_q;
    assign frame_error = ferr_q;
endmodule
